branch_resolve_stage: RTL and testbench

//  EX-stage consumer of sub-unit results: takes the C/Z/V/S flags of rs-rt plus branch op, PC+4 and offset,

---
 rtl/branch_resolve_stage_pkg.sv | 22 ++
 rtl/branch_resolve_stage_if.sv | 33 +++
 rtl/branch_resolve_stage_cond_eval.sv | 29 ++
 rtl/branch_resolve_stage.sv | 132 +++++++++++++
 tb/tb_branch_resolve_stage.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_stage_pkg.sv
// Shared encodings for the branch resolve stage: branch ops and redirect/flush FSM states.
// Purely declarative; no timing or backpressure of its own.
package branch_resolve_stage_pkg;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_BEQ  = 3'd1,
      BR_BNE  = 3'd2,
      BR_BLT  = 3'd3,
      BR_BGE  = 3'd4,
      BR_BLTU = 3'd5,
      BR_BGEU = 3'd6,
      BR_RSVD = 3'd7
   } br_op_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_FLUSH    = 2'd2
   } state_e;

endpackage

// File: rtl/branch_resolve_stage_if.sv
// Bundle of the upstream branch-candidate handshake, EX/MEM slot handshake and front-end redirect.
// master drives candidates and slot drain; slave is the resolve stage.
interface branch_resolve_stage_if #(
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = 3
);
   logic                  inValid;
   logic                  inReady;
   logic [OP_WIDTH-1:0]   branchOp;
   logic                  C;
   logic                  Z;
   logic                  V;
   logic                  S;
   logic [DATA_WIDTH-1:0] pcPlus4;
   logic [DATA_WIDTH-1:0] branchOffset;
   logic                  outValid;
   logic                  outReady;
   logic                  outTaken;
   logic [DATA_WIDTH-1:0] outTarget;
   logic                  redirectValid;
   logic [DATA_WIDTH-1:0] redirectPc;
   logic                  flushYounger;

   modport master (
      output inValid, branchOp, C, Z, V, S, pcPlus4, branchOffset, outReady,
      input  inReady, outValid, outTaken, outTarget, redirectValid, redirectPc, flushYounger
   );

   modport slave (
      input  inValid, branchOp, C, Z, V, S, pcPlus4, branchOffset, outReady,
      output inReady, outValid, outTaken, outTarget, redirectValid, redirectPc, flushYounger
   );
endinterface

// File: rtl/branch_resolve_stage_cond_eval.sv
// Combinational branch condition: maps branch op and rs-rt flags to a taken decision.
// Zero latency, no state, no backpressure.
module branch_cond_eval
   import branch_resolve_stage_pkg::*;
#(
   parameter int OP_WIDTH = 3
) (
   input  logic [OP_WIDTH-1:0] op,
   input  logic                c,
   input  logic                z,
   input  logic                v,
   input  logic                s,
   output logic                taken
);

   always_comb begin
      taken = 1'b0;
      case (op)
         OP_WIDTH'(BR_BEQ):  taken = z;
         OP_WIDTH'(BR_BNE):  taken = !z;
         OP_WIDTH'(BR_BLT):  taken = s ^ v;
         OP_WIDTH'(BR_BGE):  taken = !(s ^ v);
         OP_WIDTH'(BR_BLTU): taken = c;
         OP_WIDTH'(BR_BGEU): taken = !c;
         default:            taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_stage.sv
// EX-stage branch resolve: 1-cycle registered decision/target into EX/MEM slot, taken branch fires a redirect
// pulse and holds flushYounger for FLUSH_CYCLES; inReady drops while flushing or while the full slot is stalled.
module branch_resolve_stage
   import branch_resolve_stage_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int OP_WIDTH     = 3,
   parameter int FLUSH_CYCLES = 2
) (
   input logic                    clk,
   input logic                    rst_n,
   branch_resolve_stage_if.slave  bus
);

   localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_taken_q, out_taken_d;
   logic [DATA_WIDTH-1:0] out_target_q, out_target_d;
   logic                  redirect_valid_q, redirect_valid_d;
   logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
   logic                  flush_q, flush_d;

   logic                  taken;
   logic                  in_ready;
   logic                  accept;
   logic [DATA_WIDTH-1:0] target;

   branch_cond_eval #(.OP_WIDTH(OP_WIDTH)) u_cond (
      .op    (bus.branchOp),
      .c     (bus.C),
      .z     (bus.Z),
      .v     (bus.V),
      .s     (bus.S),
      .taken (taken)
   );

   assign target   = bus.pcPlus4 + (bus.branchOffset << 2);
   assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.outReady);
   assign accept   = bus.inValid && in_ready;

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      out_valid_d      = out_valid_q;
      out_taken_d      = out_taken_q;
      out_target_d     = out_target_q;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      flush_d          = flush_q;

      // A new accept reloads the slot even when the old entry drains on the same edge.
      if (accept) begin
         out_valid_d  = 1'b1;
         out_taken_d  = taken;
         out_target_d = target;
      end else if (bus.outReady) begin
         out_valid_d  = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept && taken) begin
               state_d          = ST_REDIRECT;
               redirect_valid_d = 1'b1;
               redirect_pc_d    = target;
               flush_d          = 1'b1;
               cnt_d            = '0;
            end
         end
         ST_REDIRECT: begin
            if (FLUSH_CYCLES > 1) begin
               state_d = ST_FLUSH;
               cnt_d   = CNT_W'(1);
               flush_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
               flush_d = 1'b0;
            end
         end
         ST_FLUSH: begin
            // The redirect cycle counts toward the window, so FLUSH lasts FLUSH_CYCLES-1 cycles.
            if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               flush_d = 1'b0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               flush_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            flush_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_IDLE;
         cnt_q            <= '0;
         out_valid_q      <= 1'b0;
         out_taken_q      <= 1'b0;
         out_target_q     <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         flush_q          <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         out_valid_q      <= out_valid_d;
         out_taken_q      <= out_taken_d;
         out_target_q     <= out_target_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         flush_q          <= flush_d;
      end
   end

   assign bus.inReady       = in_ready;
   assign bus.outValid      = out_valid_q;
   assign bus.outTaken      = out_taken_q;
   assign bus.outTarget     = out_target_q;
   assign bus.redirectValid = redirect_valid_q;
   assign bus.redirectPc    = redirect_pc_q;
   assign bus.flushYounger  = flush_q;

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Bench for branch_resolve_stage: vector table, hand-written corner sequences and a randomized run
// compared against an operand-level reference model. Instance A uses a 2-cycle flush, instance B a 4-cycle flush.
module tb_branch_resolve_stage;

   localparam int FC_A = 2;
   localparam int FC_B = 4;

   logic clk = 1'b0;
   logic rst_n_a;
   logic rst_n_b;
   always #5 clk = ~clk;

   branch_resolve_stage_if #(.DATA_WIDTH(32), .OP_WIDTH(3)) ifa ();
   branch_resolve_stage_if #(.DATA_WIDTH(32), .OP_WIDTH(3)) ifb ();

   branch_resolve_stage #(.DATA_WIDTH(32), .OP_WIDTH(3), .FLUSH_CYCLES(FC_A)) dut_a (
      .clk(clk), .rst_n(rst_n_a), .bus(ifa)
   );
   branch_resolve_stage #(.DATA_WIDTH(32), .OP_WIDTH(3), .FLUSH_CYCLES(FC_B)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .bus(ifb)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] pc;
      logic [31:0] off;
      logic        taken;
      logic [31:0] target;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Flags of rs - rt as the upstream subtract unit would produce them: {C, Z, V, S}.
   function automatic logic [3:0] flags_of(input logic [31:0] rs, input logic [31:0] rt);
      logic [31:0] d;
      d = rs - rt;
      return {rs < rt, d == 32'd0, (rs[31] != rt[31]) && (d[31] != rs[31]), d[31]};
   endfunction

   function automatic logic ref_taken(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      case (op)
         3'd1:    return rs == rt;
         3'd2:    return rs != rt;
         3'd3:    return $signed(rs) <  $signed(rt);
         3'd4:    return $signed(rs) >= $signed(rt);
         3'd5:    return rs <  rt;
         3'd6:    return rs >= rt;
         default: return 1'b0;
      endcase
   endfunction

   task automatic drive_a(input logic vld, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] pc, input logic [31:0] off, input logic ordy);
      logic [3:0] f;
      f = flags_of(rs, rt);
      ifa.inValid = vld;
      ifa.branchOp = op;
      {ifa.C, ifa.Z, ifa.V, ifa.S} = f;
      ifa.pcPlus4 = pc;
      ifa.branchOffset = off;
      ifa.outReady = ordy;
   endtask

   task automatic drive_b(input logic vld, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] pc, input logic [31:0] off);
      logic [3:0] f;
      f = flags_of(rs, rt);
      ifb.inValid = vld;
      ifb.branchOp = op;
      {ifb.C, ifb.Z, ifb.V, ifb.S} = f;
      ifb.pcPlus4 = pc;
      ifb.branchOffset = off;
      ifb.outReady = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        m_ov, m_taken, m_rv, m_ready, acc, tk, vld, ordy;
      logic [31:0] m_target, m_rpc, tgt, rs, rt, pc, off;
      logic [2:0]  op;
      int          m_fl_left, nflush, nredir;

      vecs[0]  = '{3'd1, 32'd5,          32'd5,          32'h100,        32'h4,          1'b1, 32'h110};
      vecs[1]  = '{3'd2, 32'd5,          32'd5,          32'h100,        32'h4,          1'b0, 32'h110};
      vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'd1,          32'h200,        32'h10,         1'b1, 32'h240};
      vecs[3]  = '{3'd5, 32'hFFFF_FFFF,  32'd1,          32'h200,        32'h10,         1'b0, 32'h240};
      vecs[4]  = '{3'd4, 32'd1,          32'hFFFF_FFFF,  32'h1000,       32'hFFFF_FFFF,  1'b1, 32'hFFC};
      vecs[5]  = '{3'd6, 32'd1,          32'hFFFF_FFFF,  32'h1000,       32'hFFFF_FFFF,  1'b0, 32'hFFC};
      vecs[6]  = '{3'd1, 32'd3,          32'd3,          32'hFFFF_FFFC,  32'h1,          1'b1, 32'h0};
      vecs[7]  = '{3'd0, 32'd0,          32'd0,          32'h100,        32'hFFFF_FFFF,  1'b0, 32'hFC};
      vecs[8]  = '{3'd7, 32'd0,          32'd0,          32'h40,         32'h2,          1'b0, 32'h48};
      vecs[9]  = '{3'd3, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h0,          32'h0,          1'b0, 32'h0};
      vecs[10] = '{3'd4, 32'h8000_0000,  32'd1,          32'h10,         32'h3,          1'b0, 32'h1C};
      vecs[11] = '{3'd5, 32'd0,          32'd1,          32'h20,         32'h8,          1'b1, 32'h40};
      vecs[12] = '{3'd6, 32'd5,          32'd5,          32'h0,          32'h4000_0000,  1'b1, 32'h0};

      rst_n_a = 1'b0;
      rst_n_b = 1'b0;
      drive_a(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
      drive_b(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      #12;
      chk("rst_outValid", ifa.outValid, 1'b0);
      chk("rst_outTaken", ifa.outTaken, 1'b0);
      chk("rst_outTarget", ifa.outTarget, 32'h0);
      chk("rst_redirectValid", ifa.redirectValid, 1'b0);
      chk("rst_redirectPc", ifa.redirectPc, 32'h0);
      chk("rst_flush", ifa.flushYounger, 1'b0);
      chk("rst_inReady", ifa.inReady, 1'b1);
      #8;
      rst_n_a = 1'b1;
      rst_n_b = 1'b1;
      tick();

      // Table vectors, each applied in isolation and allowed to finish its flush window.
      for (int i = 0; i < 13; i++) begin
         drive_a(1'b1, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].pc, vecs[i].off, 1'b1);
         #1;
         chk($sformatf("vec%0d_inReady", i), ifa.inReady, 1'b1);
         tick();
         ifa.inValid = 1'b0;
         chk($sformatf("vec%0d_outValid", i), ifa.outValid, 1'b1);
         chk($sformatf("vec%0d_outTaken", i), ifa.outTaken, vecs[i].taken);
         chk($sformatf("vec%0d_outTarget", i), ifa.outTarget, vecs[i].target);
         chk($sformatf("vec%0d_redirect", i), ifa.redirectValid, vecs[i].taken);
         chk($sformatf("vec%0d_flush", i), ifa.flushYounger, vecs[i].taken);
         if (vecs[i].taken) chk($sformatf("vec%0d_redirectPc", i), ifa.redirectPc, vecs[i].target);
         for (int k = 0; k < 3; k++) tick();
         chk($sformatf("vec%0d_settle_flush", i), ifa.flushYounger, 1'b0);
         chk($sformatf("vec%0d_settle_inReady", i), ifa.inReady, 1'b1);
      end

      // Taken BEQ: redirect pulse one cycle, flush and inReady-low for two cycles.
      drive_a(1'b1, 3'd1, 32'd7, 32'd7, 32'h100, 32'h4, 1'b1);
      tick();
      ifa.inValid = 1'b0;
      chk("t1_outTarget", ifa.outTarget, 32'h110);
      chk("t1_redirect_c0", ifa.redirectValid, 1'b1);
      chk("t1_redirectPc", ifa.redirectPc, 32'h110);
      chk("t1_flush_c0", ifa.flushYounger, 1'b1);
      chk("t1_inReady_c0", ifa.inReady, 1'b0);
      tick();
      chk("t1_redirect_c1", ifa.redirectValid, 1'b0);
      chk("t1_flush_c1", ifa.flushYounger, 1'b1);
      chk("t1_inReady_c1", ifa.inReady, 1'b0);
      tick();
      chk("t1_flush_c2", ifa.flushYounger, 1'b0);
      chk("t1_inReady_c2", ifa.inReady, 1'b1);

      // Slot backpressure, then reload on the same edge the old entry drains.
      drive_a(1'b1, 3'd0, 32'd0, 32'd0, 32'h300, 32'h1, 1'b1);
      tick();
      drive_a(1'b1, 3'd0, 32'd0, 32'd0, 32'h500, 32'h0, 1'b0);
      #1;
      chk("t4_inReady_stall", ifa.inReady, 1'b0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("t4_hold%0d_outValid", k), ifa.outValid, 1'b1);
         chk($sformatf("t4_hold%0d_outTarget", k), ifa.outTarget, 32'h304);
         chk($sformatf("t4_hold%0d_inReady", k), ifa.inReady, 1'b0);
      end
      ifa.outReady = 1'b1;
      #1;
      chk("t4_inReady_drain", ifa.inReady, 1'b1);
      tick();
      ifa.inValid = 1'b0;
      chk("t4_reload_outValid", ifa.outValid, 1'b1);
      chk("t4_reload_outTarget", ifa.outTarget, 32'h500);
      tick();
      chk("t4_drained_outValid", ifa.outValid, 1'b0);

      // NONE and reserved op with every flag combination, one accept per cycle.
      for (int i = 0; i < 32; i++) begin
         ifa.inValid = 1'b1;
         ifa.branchOp = (i < 16) ? 3'd0 : 3'd7;
         {ifa.C, ifa.Z, ifa.V, ifa.S} = 4'(i);
         ifa.pcPlus4 = 32'h1000 + 32'(i * 4);
         ifa.branchOffset = 32'h0;
         ifa.outReady = 1'b1;
         #1;
         chk($sformatf("t6_%0d_inReady", i), ifa.inReady, 1'b1);
         tick();
         chk($sformatf("t6_%0d_outValid", i), ifa.outValid, 1'b1);
         chk($sformatf("t6_%0d_outTaken", i), ifa.outTaken, 1'b0);
         chk($sformatf("t6_%0d_redirect", i), ifa.redirectValid, 1'b0);
         chk($sformatf("t6_%0d_outTarget", i), ifa.outTarget, 32'h1000 + 32'(i * 4));
      end
      ifa.inValid = 1'b0;

      // Instance B: full 4-cycle flush window, then a reset in the 2nd FLUSH cycle.
      drive_b(1'b1, 3'd2, 32'd1, 32'd2, 32'h80, 32'h1);
      tick();
      ifb.inValid = 1'b0;
      nflush = 0;
      nredir = 0;
      for (int k = 0; k < 6; k++) begin
         if (ifb.flushYounger) nflush++;
         if (ifb.redirectValid) nredir++;
         tick();
      end
      chk("t5_flush_window", nflush, FC_B);
      chk("t5_redirect_count", nredir, 1);

      drive_b(1'b1, 3'd1, 32'd9, 32'd9, 32'h100, 32'h4);
      tick();
      ifb.inValid = 1'b0;
      chk("t5_redirect", ifb.redirectValid, 1'b1);
      tick();
      tick();
      chk("t5_flush_mid", ifb.flushYounger, 1'b1);
      chk("t5_inReady_mid", ifb.inReady, 1'b0);
      #2;
      rst_n_b = 1'b0;
      #1;
      chk("t5_rst_outValid", ifb.outValid, 1'b0);
      chk("t5_rst_outTaken", ifb.outTaken, 1'b0);
      chk("t5_rst_outTarget", ifb.outTarget, 32'h0);
      chk("t5_rst_redirect", ifb.redirectValid, 1'b0);
      chk("t5_rst_redirectPc", ifb.redirectPc, 32'h0);
      chk("t5_rst_flush", ifb.flushYounger, 1'b0);
      #2;
      rst_n_b = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("t5_post%0d_redirect", k), ifb.redirectValid, 1'b0);
         chk($sformatf("t5_post%0d_flush", k), ifb.flushYounger, 1'b0);
         chk($sformatf("t5_post%0d_inReady", k), ifb.inReady, 1'b1);
      end

      // Randomized run on instance A against the reference model, from a fresh reset.
      rst_n_a = 1'b0;
      #2;
      rst_n_a = 1'b1;
      m_ov = 1'b0; m_taken = 1'b0; m_target = 32'h0;
      m_rv = 1'b0; m_rpc = 32'h0; m_fl_left = 0;
      for (int it = 0; it < 400; it++) begin
         chk("rnd_outValid", ifa.outValid, m_ov);
         if (m_ov) begin
            chk("rnd_outTaken", ifa.outTaken, m_taken);
            chk("rnd_outTarget", ifa.outTarget, m_target);
         end
         chk("rnd_redirect", ifa.redirectValid, m_rv);
         if (m_rv) chk("rnd_redirectPc", ifa.redirectPc, m_rpc);
         chk("rnd_flush", ifa.flushYounger, m_fl_left > 0);

         vld  = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 3) != 0);
         op   = 3'($urandom_range(0, 7));
         rs   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
         rt   = ($urandom_range(0, 3) == 0) ? rs : 32'($urandom);
         pc   = 32'($urandom);
         off  = ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($signed(16'($urandom)));
         drive_a(vld, op, rs, rt, pc, off, ordy);
         #1;
         m_ready = (m_fl_left == 0) && (!m_ov || ordy);
         chk("rnd_inReady", ifa.inReady, m_ready);
         acc = vld && m_ready;
         tk  = ref_taken(op, rs, rt);
         tgt = pc + (off << 2);
         tick();

         if (acc) begin
            m_ov = 1'b1;
            m_taken = tk;
            m_target = tgt;
         end else if (ordy) begin
            m_ov = 1'b0;
         end
         if (m_fl_left > 0) m_fl_left--;
         m_rv = 1'b0;
         if (acc && tk) begin
            m_fl_left = FC_A;
            m_rv = 1'b1;
            m_rpc = tgt;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
